rs232_receive_frame: RTL

- Parametrised successor to the bare RS232 receiver.
- Oversampling UART receiver with configurable data width, parity mode and stop-bit count, and a 2-FF input synchroniser.
- Reports framing, parity, break and overrun errors, and delivers bytes through a valid/ready handshake.
- Sits between the `rs232_txd` pin and application logic (LED display, command parser, FIFO).

---
 rtl/rs232_pkg.sv | 28 ++
 rtl/rs232_sync_sample.sv | 66 ++++++
 rtl/rs232_receive_frame.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the oversampling RS232 receiver: FSM state codes,
// parity-mode constants and bit-timing helpers.
package rs232_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef logic [2:0] rs232_state_t;

    localparam rs232_state_t StIdle     = 3'd0;
    localparam rs232_state_t StStart    = 3'd1;
    localparam rs232_state_t StData     = 3'd2;
    localparam rs232_state_t StParity   = 3'd3;
    localparam rs232_state_t StStop     = 3'd4;
    localparam rs232_state_t StWaitHigh = 3'd5;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned rs232_div(input int unsigned clock_freq,
                                              input int unsigned baud_rate);
        return (clock_freq + baud_rate / 2) / baud_rate;
    endfunction

    function automatic int unsigned rs232_cnt_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/rs232_sync_sample.sv
// Two-flop line synchroniser plus bit sampler. With RS232_RX_MAJORITY_EN defined
// each sample is a 2-of-3 vote around the tick and is presented one clock later.
module rs232_sync_sample
    import rs232_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic rxd_i,
    input  logic tick_i,
    output logic line_o,
    output logic sample_valid_o,
    output logic sample_bit_o
);

    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], rxd_i};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign line_o = sync_q[1];

`ifdef RS232_RX_MAJORITY_EN
    logic       prev_q, prev_d;
    logic [1:0] pair_q, pair_d;
    logic       pend_q, pend_d;

    // pair_q captures the samples at tick-1 and tick; the third arrives next clock.
    always_comb begin
        prev_d = sync_q[1];
        pair_d = pair_q;
        if (tick_i) begin
            pair_d = {prev_q, sync_q[1]};
        end
        pend_d = tick_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b1;
            pair_q <= 2'b11;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            pair_q <= pair_d;
            pend_q <= pend_d;
        end
    end

    assign sample_valid_o = pend_q;
    assign sample_bit_o   = (pair_q[1] & pair_q[0]) | (pair_q[1] & sync_q[1]) |
                            (pair_q[0] & sync_q[1]);
`else
    assign sample_valid_o = tick_i;
    assign sample_bit_o   = sync_q[1];
`endif

endmodule

// File: rtl/rs232_receive_frame.sv
// Oversampling RS232 frame receiver with parity/framing/break/overrun reporting and a
// valid/ready output. Optional 2-of-3 majority sampling via RS232_RX_MAJORITY_EN.
module rs232_receive_frame
    import rs232_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 133000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rs232_txd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 break_detect,
    output logic                 overrun
);

    localparam int unsigned DIV   = rs232_div(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = rs232_cnt_width(DIV);

    localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(DIV / 2 - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (DIV < 8) begin : g_div_check
            $error("rs232_receive_frame: CLOCK_FREQ/BAUD_RATE must be at least 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_check
            $error("rs232_receive_frame: DATA_BITS must be 5..9");
        end
        if (PARITY > 2) begin : g_parity_check
            $error("rs232_receive_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
            $error("rs232_receive_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    logic line;
    logic tick;
    logic sample_valid;
    logic sample_bit;

    rs232_sync_sample u_sync_sample (
        .clock          (clock),
        .reset          (reset),
        .rxd_i          (rs232_txd),
        .tick_i         (tick),
        .line_o         (line),
        .sample_valid_o (sample_valid),
        .sample_bit_o   (sample_bit)
    );

    rs232_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_q, ferr_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 frame_err_q, frame_err_d;
    logic                 brk_q, brk_d;
    logic                 ovr_q, ovr_d;

    logic busy;
    logic frame_done;
    logic new_ferr;
    logic new_perr;
    logic new_brk;
    logic par_xor;
    logic accept;

    assign busy = (state_q == StStart) || (state_q == StData) ||
                  (state_q == StParity) || (state_q == StStop);
    assign tick = busy && (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;
        new_ferr   = ferr_q;

        if (busy) begin
            cnt_d = tick ? DIV_M1 : cnt_q - 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (!line) begin
                    state_d = StStart;
                    cnt_d   = HALF_M1;
                end
            end
            StStart: begin
                if (sample_valid) begin
                    if (sample_bit) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_cnt_d = 4'd0;
                        ferr_d    = 1'b0;
                        par_bit_d = 1'b0;
                    end
                end
            end
            StData: begin
                if (sample_valid) begin
                    shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = 4'd0;
                        state_d   = (PARITY != PARITY_NONE) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (sample_valid) begin
                    par_bit_d = sample_bit;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (sample_valid) begin
                    new_ferr = ferr_q | ~sample_bit;
                    ferr_d   = new_ferr;
                    if (bit_cnt_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        // A low stop bit may be a break; wait for the line to recover.
                        state_d    = new_ferr ? StWaitHigh : StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StWaitHigh: begin
                if (line) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        par_xor = (^shift_q) ^ par_bit_q;
        if (PARITY == PARITY_ODD) begin
            new_perr = ~par_xor;
        end else if (PARITY == PARITY_EVEN) begin
            new_perr = par_xor;
        end else begin
            new_perr = 1'b0;
        end
        new_brk = new_ferr && (shift_q == '0) && !par_bit_q;
    end

    assign accept = valid_q & ready;

    always_comb begin
        data_d      = data_q;
        perr_d      = perr_q;
        frame_err_d = frame_err_q;
        brk_d       = brk_q;
        valid_d     = valid_q & ~accept;
        ovr_d       = 1'b0;
        if (frame_done) begin
            if (!valid_q || accept) begin
                data_d      = shift_q;
                perr_d      = new_perr;
                frame_err_d = new_ferr;
                brk_d       = new_brk;
                valid_d     = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            ferr_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
            brk_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            ferr_q      <= ferr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            frame_err_q <= frame_err_d;
            brk_q       <= brk_d;
            ovr_q       <= ovr_d;
        end
    end

    assign data         = data_q;
    assign valid        = valid_q;
    assign parity_error = perr_q;
    assign frame_error  = frame_err_q;
    assign break_detect = brk_q;
    assign overrun      = ovr_q;

endmodule
